// File: rtl/acia_rxfifo.sv
// acia_rxfifo -- receive FIFO between a serial receiver and the bus-side data register.
//
// Each entry holds the received byte and its framing/error flag. The FIFO is
// first-word-fall-through: the head entry is always presented on rd_dat/rd_err
// while the FIFO is non-empty, and both read as zero when it is empty. A push
// into a full FIFO without a concurrent pop drops the byte and sets a sticky
// overrun flag.
//
// Optional feature: define ACIA_RXFIFO_HWM_EN to enable the registered
// half-full indication on hwm. Without it, hwm is tied to 0.
//
// Parameters:
//   DEPTH    entry count, power of two, 2..64
//   CW       count width, $clog2(DEPTH)+1
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-low reset
//   wr_dat   received byte from serial receiver
//   wr_err   error flag accompanying wr_dat
//   wr_stb   one-cycle push strobe
//   rd       pop strobe from bus side
//   flush    synchronous discard of all entries (highest priority)
//   clr_ovr  clear sticky overrun
//   rd_dat   head-entry byte (0 when empty)
//   rd_err   head-entry error flag (0 when empty)
//   empty    no entries held
//   full     DEPTH entries held
//   count    entries held, 0..DEPTH
//   ovr      sticky overrun
//   hwm      half-full indication (count >= DEPTH/2) when enabled

module acia_rxfifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_dat,
  input  logic          wr_err,
  input  logic          wr_stb,
  input  logic          rd,
  input  logic          flush,
  input  logic          clr_ovr,
  output logic [7:0]    rd_dat,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          ovr,
  output logic          hwm
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          do_push, do_pop, ovr_set;
  logic [8:0]    head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign ovr   = ovr_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when it is popped concurrently. Flush cancels both.
  assign do_pop  = rd & ~empty & ~flush;
  assign do_push = wr_stb & (~full | (rd & ~empty)) & ~flush;
  assign ovr_set = wr_stb & full & ~rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
      // Set wins over a same-cycle clear so an overrun is never lost.
      if (ovr_set)      ovr_d = 1'b1;
      else if (clr_ovr) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage is deliberately unreset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {wr_err, wr_dat};
  end

  assign head   = empty ? 9'd0 : mem_q[rd_ptr_q];
  assign rd_dat = head[7:0];
  assign rd_err = head[8];

`ifdef ACIA_RXFIFO_HWM_EN
  logic hwm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hwm_q <= 1'b0;
    else      hwm_q <= (count_d >= CW'(DEPTH / 2));
  end

  assign hwm = hwm_q;
`else
  assign hwm = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rxfifo.sv
// Directed self-checking bench for acia_rxfifo at DEPTH=8.
module tb_acia_rxfifo;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_dat;
  logic          wr_err;
  logic          wr_stb;
  logic          rd;
  logic          flush;
  logic          clr_ovr;
  logic [7:0]    rd_dat;
  logic          rd_err;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          ovr;
  logic          hwm;

  int tests = 0;
  int fails = 0;

  acia_rxfifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_dat  (wr_dat),
    .wr_err  (wr_err),
    .wr_stb  (wr_stb),
    .rd      (rd),
    .flush   (flush),
    .clr_ovr (clr_ovr),
    .rd_dat  (rd_dat),
    .rd_err  (rd_err),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovr     (ovr),
    .hwm     (hwm)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: inputs change at posedge+1, outputs sampled at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic e);
    wr_dat = b; wr_err = e; wr_stb = 1'b1;
    step();
    wr_stb = 1'b0; wr_dat = 8'h00; wr_err = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_stb = 1'b1; rd = 1'b1; wr_dat = 8'hAA; wr_err = 1'b1;
    step();
    step();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %0b want 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0b want 0", full); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %0b want 0", ovr); end
    tests++; if (hwm !== 1'b0) begin fails++; $display("FAIL reset_hwm: got %0b want 0", hwm); end
    tests++; if ({rd_err, rd_dat} !== 9'h000) begin
      fails++; $display("FAIL reset_rd: got %0h want 0", {rd_err, rd_dat});
    end
    wr_stb = 1'b0; rd = 1'b0; wr_dat = 8'h00; wr_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL post_reset_empty: got %0b want 1", empty); end
  endtask

  task automatic test_single_push();
    push(8'h41, 1'b0);
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL push1_empty: got %0b want 0", empty); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL push1_count: got %0d want 1", count); end
    tests++; if (rd_dat !== 8'h41) begin fails++; $display("FAIL push1_dat: got %0h want 41", rd_dat); end
    tests++; if (rd_err !== 1'b0) begin fails++; $display("FAIL push1_err: got %0b want 0", rd_err); end
    pop();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pop1_empty: got %0b want 1", empty); end
  endtask

  task automatic test_rd_empty();
    pop();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL rd_empty_count: got %0d want 0", count); end
    push(8'hC3, 1'b1);
    tests++; if ({rd_err, rd_dat} !== 9'h1C3) begin
      fails++; $display("FAIL rd_empty_head: got %0h want 1c3", {rd_err, rd_dat});
    end
    do_flush();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) push(8'(i), 1'b0);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %0b want 1", full); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL fill_ovr: got %0b want 0", ovr); end
    push(8'h08, 1'b0);
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovr_count: got %0d want 8", count); end
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_set: got %0b want 1", ovr); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rd_dat !== 8'(i)) begin
        fails++; $display("FAIL ovr_pop%0d: got %0h want %0h", i, rd_dat, i);
      end
      pop();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovr_drain_empty: got %0b want 1", empty); end
    tests++; if (rd_dat !== 8'h00) begin fails++; $display("FAIL ovr_drain_dat: got %0h want 0", rd_dat); end
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %0b want 1", ovr); end
    do_flush();
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
    rd = 1'b1;
    push(8'h55, 1'b0);
    rd = 1'b0;
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fullrw_count: got %0d want 8", count); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL fullrw_ovr: got %0b want 0", ovr); end
    tests++; if (rd_dat !== 8'h11) begin fails++; $display("FAIL fullrw_head: got %0h want 11", rd_dat); end
    for (int i = 0; i < 7; i++) pop();
    tests++; if (rd_dat !== 8'h55) begin fails++; $display("FAIL fullrw_last: got %0h want 55", rd_dat); end
    pop();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fullrw_empty: got %0b want 1", empty); end
  endtask

  task automatic test_empty_rdwr();
    rd = 1'b1;
    push(8'h7E, 1'b1);
    rd = 1'b0;
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL emptyrw_count: got %0d want 1", count); end
    tests++; if (rd_dat !== 8'h7E) begin fails++; $display("FAIL emptyrw_dat: got %0h want 7e", rd_dat); end
    tests++; if (rd_err !== 1'b1) begin fails++; $display("FAIL emptyrw_err: got %0b want 1", rd_err); end
    // Mid-range simultaneous push/pop keeps count and advances head.
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    rd = 1'b1;
    push(8'h44, 1'b0);
    rd = 1'b0;
    tests++; if (count !== 4'd3) begin fails++; $display("FAIL midrw_count: got %0d want 3", count); end
    tests++; if ({rd_err, rd_dat} !== 9'h022) begin
      fails++; $display("FAIL midrw_head: got %0h want 22", {rd_err, rd_dat});
    end
    do_flush();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) pop();
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL flush_pre_ovr: got %0b want 1", ovr); end
    flush = 1'b1;
    push(8'hEE, 1'b1);
    flush = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %0b want 1", empty); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL flush_ovr: got %0b want 0", ovr); end
    tests++; if (rd_dat !== 8'h00) begin fails++; $display("FAIL flush_dat: got %0h want 0", rd_dat); end
    push(8'h33, 1'b0);
    tests++; if (rd_dat !== 8'h33) begin fails++; $display("FAIL flush_repush: got %0h want 33", rd_dat); end
    do_flush();
  endtask

  task automatic test_clr_ovr();
    for (int i = 0; i < 9; i++) push(8'(i), 1'b0);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL clr_ovr: got %0b want 0", ovr); end
    clr_ovr = 1'b1;
    push(8'h99, 1'b0);
    clr_ovr = 1'b0;
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL clr_vs_set: got %0b want 1", ovr); end
    tests++; if (rd_dat !== 8'h00) begin fails++; $display("FAIL clr_head: got %0h want 0", rd_dat); end
    do_flush();
  endtask

  task automatic test_async_reset();
    push(8'h12, 1'b0);
    push(8'h34, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL areset_empty: got %0b want 1", empty); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_hwm();
    logic [3:0] exp_hwm;
`ifdef ACIA_RXFIFO_HWM_EN
    exp_hwm = 4'b1000;
`else
    exp_hwm = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      push(8'h60 + 8'(i), 1'b0);
      tests++; if (hwm !== exp_hwm[i]) begin
        fails++; $display("FAIL hwm_push%0d: got %0b want %0b", i + 1, hwm, exp_hwm[i]);
      end
    end
    pop();
    tests++; if (hwm !== 1'b0) begin fails++; $display("FAIL hwm_pop: got %0b want 0", hwm); end
    do_flush();
  endtask

  initial begin
    rst = 1'b0; wr_dat = 8'h00; wr_err = 1'b0; wr_stb = 1'b0;
    rd = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
    test_reset();
    test_single_push();
    test_rd_empty();
    test_overrun();
    test_full_rdwr();
    test_empty_rdwr();
    test_flush();
    test_clr_ovr();
    test_async_reset();
    test_hwm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/acia_rxfifo.md
ACIA_RXFIFO -- requirements
Module: acia_rxfifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, 2..64.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, count width.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_dat  input  8  received byte from serial receiver.
REQ-006 SHALL have port wr_err  input  1  framing/error flag accompanying wr_dat.
REQ-007 SHALL have port wr_stb  input  1  one-cycle push strobe from receiver.
REQ-008 SHALL have port rd  input  1  pop strobe from bus side (data-register read).
REQ-009 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-010 SHALL have port clr_ovr  input  1  clear sticky overrun.
REQ-011 SHALL have port rd_dat  output  8  head-entry byte.
REQ-012 SHALL have port rd_err  output  1  head-entry error flag.
REQ-013 SHALL have port empty  output  1  no entries held.
REQ-014 SHALL have port full  output  1  DEPTH entries held.
REQ-015 SHALL have port count  output  CW  entries held, 0..DEPTH.
REQ-016 SHALL have port ovr  output  1  sticky overrun.
REQ-017 SHALL have port hwm  output  1  half-full indication (see Configuration).

Function
REQ-018 SHALL store {wr_err, wr_dat} (9 bits) per entry in register array, write pointer, read pointer, count register.
REQ-019 SHALL be first-word-fall-through: rd_dat/rd_err show head entry whenever empty=0, no read latency.
REQ-020 SHALL drive rd_dat=0, rd_err=0 while empty=1.
REQ-021 SHALL accept push when wr_stb=1 and full=0; entry visible at head the cycle after push into empty FIFO.
REQ-022 SHALL accept pop when rd=1 and empty=0; rd while empty ignored, no state change.
REQ-023 SHALL wrap both pointers modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-024 SHALL, for wr_stb=1 with full=1 and rd=0, drop byte, leave contents intact, set ovr next edge.
REQ-025 SHALL, for wr_stb=1 and rd=1 while full, perform pop and push; count stays DEPTH, ovr unchanged.
REQ-026 SHALL, for wr_stb=1 and rd=1 while empty, perform push only; count becomes 1.
REQ-027 SHALL, for simultaneous push and pop with 0<count<DEPTH, keep count unchanged and advance both pointers.
REQ-028 SHALL give flush priority over push and pop: pointers and count to 0, ovr cleared, concurrent wr_stb byte discarded.
REQ-029 SHALL hold ovr until clr_ovr, flush, or reset; same-cycle set and clr_ovr SHALL leave ovr=1.
REQ-030 SHALL derive empty=(count==0), full=(count==DEPTH) from registered count.

Reset
REQ-031 SHALL on rst=0 asynchronously set pointers=0, count=0, empty=1, full=0, ovr=0, hwm=0, rd_dat=0, rd_err=0.
REQ-032 SHALL leave storage array unreset; contents unobservable until written.
REQ-033 SHALL discard any wr_stb or rd coincident with reset assertion; operate from first edge after rst=1.

Configuration
REQ-034 SHALL with ACIA_RXFIFO_HWM_EN defined drive hwm as registered (count >= DEPTH/2), updated same edge as count.
REQ-035 SHALL without ACIA_RXFIFO_HWM_EN keep hwm port, tied to 0, and contain no comparator logic.

Verification
REQ-036 SHALL cover: reset, push 0x41 err=0 -> next cycle empty=0, count=1, rd_dat=0x41, rd_err=0.
REQ-037 SHALL cover: push 0x00..0x07 (DEPTH=8), push 0x08 -> full=1, ovr=1, pops return 0x00..0x07 in order, 0x08 absent.
REQ-038 SHALL cover: full FIFO, simultaneous rd and wr_stb 0x55 -> count=8, ovr=0, eighth pop returns 0x55.
REQ-039 SHALL cover: empty FIFO, simultaneous rd and wr_stb 0x7E err=1 -> count=1, rd_dat=0x7E, rd_err=1.
REQ-040 SHALL cover: count=5 with ovr=1, flush plus wr_stb same cycle -> count=0, empty=1, ovr=0, rd_dat=0.
REQ-041 SHALL cover: with ACIA_RXFIFO_HWM_EN, pushes 1..4 -> hwm rises on fourth push edge, falls on next pop; without macro hwm=0 throughout.
